axi_bus_wr_arbiter: RTL and testbench
=====================================

// Module: axi_bus_wr_arbiter
// PURPOSE
// - Shares one bus-side AXI write path (addr, data, back channels) among NUM_M masters, each already moved into B_CLK by its clock-domain bridge.
// - Round-robin grant per burst. Grant is held from the address handshake through the WR_DATA_LAST handshake.
// - Write responses are routed back to the issuing master by WR_BACK_ID.
// PARAMETERS
// NUM_M    4   number of masters; 2..4 (ID width fixed at 2 bits)
// AW       32  address width
// DW       32  data width; strobe width is DW/8
// PORTS
// B_CLK             in   1          bus clock, all logic on rising edge
// B_RSTN            in   1          asynchronous active-low reset
// M_WR_ADDR_VALID   in   NUM_M      per-master addr valid
// M_WR_ADDR_READY   out  NUM_M      per-master addr ready
// M_WR_ADDR         in   NUM_M*AW   packed; master i at [i*AW +: AW]
// M_WR_ADDR_LEN     in   NUM_M*8    beats-1
// M_WR_ADDR_BURST   in   NUM_M*2    burst type, passed through
// M_WR_DATA_VALID   in   NUM_M      per-master data valid
// M_WR_DATA_READY   out  NUM_M      per-master data ready
// M_WR_DATA         in   NUM_M*DW   packed data
// M_WR_STRB         in   NUM_M*DW/8 packed strobes
// M_WR_DATA_LAST    in   NUM_M      last beat
// M_WR_BACK_VALID   out  NUM_M      per-master response valid
// M_WR_BACK_READY   in   NUM_M      per-master response ready
// M_WR_BACK_RESP    out  NUM_M*2    response code, replicated to all masters
// S_WR_ADDR_VALID/READY out/in 1; S_WR_ADDR_ID out 2; S_WR_ADDR out AW; S_WR_ADDR_LEN out 8; S_WR_ADDR_BURST out 2
// S_WR_DATA_VALID/READY out/in 1; S_WR_DATA out DW; S_WR_STRB out DW/8; S_WR_DATA_LAST out 1
// S_WR_BACK_VALID/READY in/out 1; S_WR_BACK_ID in 2; S_WR_BACK_RESP in 2
// burst_err        out  1          sticky: LAST did not match LEN; cleared only by reset
// BEHAVIOUR
// - FSM states:
//   - IDLE: on any M_WR_ADDR_VALID, the rr arbiter picks the first requester after last_grant. Register gnt and go to ADDR the next cycle. No combinational path from M_WR_ADDR_VALID to S_WR_ADDR_VALID.
//   - ADDR: S_WR_ADDR_VALID=1, S_* = master gnt fields, S_WR_ADDR_ID=gnt, M_WR_ADDR_READY[gnt]=S_WR_ADDR_READY.
//     - On handshake: latch beat_cnt=LEN, go to DATA.
//   - DATA: S_WR_DATA_* = master gnt, M_WR_DATA_READY[gnt]=S_WR_DATA_READY. Each handshake decrements beat_cnt.
//     - On handshake with LAST=1: last_grant<=gnt, go to IDLE.
// - Handshake rules: VALID never depends on the same-channel READY. Non-granted masters see READY=0.
// - Outside ADDR/DATA, S_WR_*_VALID=0 and the data/addr buses are 0 (bus is AND-masked, as the bridges expect).
// - burst_err is set if LAST arrives with beat_cnt!=0, or if a beat arrives with beat_cnt==0 and LAST=0.
//   - On a missing LAST the burst is not ended: grant stays held until LAST.
// - Back channel: combinational and independent of the FSM.
//   - M_WR_BACK_VALID[i] = S_WR_BACK_VALID && S_WR_BACK_ID==i.
//   - S_WR_BACK_READY = M_WR_BACK_READY[S_WR_BACK_ID].
//   - An ID >= NUM_M is accepted and dropped (READY=1).
// - Multiple outstanding responses are allowed; ordering is the slave's.
// - Boundaries:
//   - A single requester is re-granted back-to-back with one IDLE cycle.
//   - LEN=0 means a single beat, and LAST is required on it.
//   - Wrap-around of last_grant is modulo NUM_M.
// - Reset (asynchronous, any state): FSM=IDLE, last_grant=NUM_M-1 (so master 0 wins first), beat_cnt=0, burst_err=0, all VALID/READY outputs=0.
//   - Reset mid-burst abandons the burst. No recovery is attempted.
// STRUCTURE
// - Package axi_bus_pkg: ID_W=2, LEN_W=8, BURST_W=2, RESP_W=2, typedef wr_arb_state_t {IDLE,ADDR,DATA}.
// - Sub-module rr_arbiter #(N): inputs req[N], last[$clog2(N)]; outputs gnt_idx, gnt_vld. Purely combinational.
// - Top: FSM, grant/beat registers, muxes, back-channel demux.
// TESTING
// 1 M0 alone, LEN=3, S ready always -> S_WR_ADDR_ID=0, 4 data beats on consecutive cycles, LAST on beat 4, back to IDLE.
// 2 M0..M3 request together after reset -> grants in order 0,1,2,3,0; no beat ever from a non-granted master.
// 3 S_WR_DATA_READY toggled 1/0 during an 8-beat burst -> every beat appears exactly once, S_* held stable while READY=0.
// 4 S_WR_BACK_ID=2, RESP=2'b10, M2 ready low 3 cycles -> only M_WR_BACK_VALID[2]=1, S_WR_BACK_READY=0 until M2 ready.
// 5 LEN=3 with LAST on beat 2 -> burst_err=1 and stays 1; arbiter returns to IDLE.
// 6 B_RSTN asserted in DATA mid-burst -> all outputs 0 immediately; next grant goes to M0.

Source files
------------

// File: rtl/axi_bus_wr_arbiter_pkg.sv
// Shared widths and FSM state type for the bus-side AXI write arbiter.
package axi_bus_pkg;

    localparam int unsigned ID_W    = 2;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } wr_arb_state_t;

endpackage

// File: rtl/axi_bus_wr_arbiter_if.sv
// Master-side (per-master lanes) and slave-side write channels of the arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface axi_bus_wr_arbiter_if #(
    parameter int unsigned NUM_M = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
);
    import axi_bus_pkg::*;

    localparam int unsigned SW = DW / 8;

    // per-master lanes
    logic [NUM_M-1:0]         m_wr_addr_valid;
    logic [NUM_M-1:0]         m_wr_addr_ready;
    logic [NUM_M*AW-1:0]      m_wr_addr;
    logic [NUM_M*LEN_W-1:0]   m_wr_addr_len;
    logic [NUM_M*BURST_W-1:0] m_wr_addr_burst;
    logic [NUM_M-1:0]         m_wr_data_valid;
    logic [NUM_M-1:0]         m_wr_data_ready;
    logic [NUM_M*DW-1:0]      m_wr_data;
    logic [NUM_M*SW-1:0]      m_wr_strb;
    logic [NUM_M-1:0]         m_wr_data_last;
    logic [NUM_M-1:0]         m_wr_back_valid;
    logic [NUM_M-1:0]         m_wr_back_ready;
    logic [NUM_M*RESP_W-1:0]  m_wr_back_resp;

    // shared bus-side path
    logic                     s_wr_addr_valid;
    logic                     s_wr_addr_ready;
    logic [ID_W-1:0]          s_wr_addr_id;
    logic [AW-1:0]            s_wr_addr;
    logic [LEN_W-1:0]         s_wr_addr_len;
    logic [BURST_W-1:0]       s_wr_addr_burst;
    logic                     s_wr_data_valid;
    logic                     s_wr_data_ready;
    logic [DW-1:0]            s_wr_data;
    logic [SW-1:0]            s_wr_strb;
    logic                     s_wr_data_last;
    logic                     s_wr_back_valid;
    logic                     s_wr_back_ready;
    logic [ID_W-1:0]          s_wr_back_id;
    logic [RESP_W-1:0]        s_wr_back_resp;

    modport master (
        input  m_wr_addr_valid, m_wr_addr, m_wr_addr_len, m_wr_addr_burst,
        input  m_wr_data_valid, m_wr_data, m_wr_strb, m_wr_data_last,
        input  m_wr_back_ready,
        output m_wr_addr_ready, m_wr_data_ready, m_wr_back_valid, m_wr_back_resp,
        output s_wr_addr_valid, s_wr_addr_id, s_wr_addr, s_wr_addr_len, s_wr_addr_burst,
        output s_wr_data_valid, s_wr_data, s_wr_strb, s_wr_data_last,
        output s_wr_back_ready,
        input  s_wr_addr_ready, s_wr_data_ready,
        input  s_wr_back_valid, s_wr_back_id, s_wr_back_resp
    );

    modport slave (
        output m_wr_addr_valid, m_wr_addr, m_wr_addr_len, m_wr_addr_burst,
        output m_wr_data_valid, m_wr_data, m_wr_strb, m_wr_data_last,
        output m_wr_back_ready,
        input  m_wr_addr_ready, m_wr_data_ready, m_wr_back_valid, m_wr_back_resp,
        input  s_wr_addr_valid, s_wr_addr_id, s_wr_addr, s_wr_addr_len, s_wr_addr_burst,
        input  s_wr_data_valid, s_wr_data, s_wr_strb, s_wr_data_last,
        input  s_wr_back_ready,
        output s_wr_addr_ready, s_wr_data_ready,
        output s_wr_back_valid, s_wr_back_id, s_wr_back_resp
    );

endinterface

// File: rtl/axi_bus_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    // Scan from farthest to nearest offset so the nearest requester overwrites.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = int'(N); k >= 1; k--) begin
            idx = (int'(last) + k) % int'(N);
            if (req[idx]) begin
                gnt_idx = IW'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_bus_wr_arbiter.sv
// Shares one bus-side AXI write path among NUM_M masters with per-burst
// round-robin grant; write responses are demuxed back by ID.
module axi_bus_wr_arbiter
    import axi_bus_pkg::*;
#(
    parameter int unsigned NUM_M = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                 B_CLK,
    input  logic                 B_RSTN,
    axi_bus_wr_arbiter_if.master bus,
    output logic                 burst_err
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned GW = $clog2(NUM_M);

    wr_arb_state_t    state;
    wr_arb_state_t    state_nxt;
    logic [GW-1:0]    gnt;
    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    arb_idx;
    logic             arb_vld;
    logic [LEN_W-1:0] beat_cnt;
    logic             addr_hs;
    logic             data_hs;
    logic             data_last;

    rr_arbiter #(.N(NUM_M)) u_rr (
        .req     (bus.m_wr_addr_valid),
        .last    (last_grant),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign addr_hs   = (state == ADDR) && bus.s_wr_addr_ready;
    assign data_last = bus.m_wr_data_last[gnt];
    assign data_hs   = (state == DATA) && bus.m_wr_data_valid[gnt] && bus.s_wr_data_ready;

    // FSM state register
    always_ff @(posedge B_CLK or negedge B_RSTN) begin
        if (!B_RSTN) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state and granted-master forwarding; buses are zero when not owned
    always_comb begin
        state_nxt           = state;
        bus.s_wr_addr_valid = 1'b0;
        bus.s_wr_addr_id    = '0;
        bus.s_wr_addr       = '0;
        bus.s_wr_addr_len   = '0;
        bus.s_wr_addr_burst = '0;
        bus.m_wr_addr_ready = '0;
        bus.s_wr_data_valid = 1'b0;
        bus.s_wr_data       = '0;
        bus.s_wr_strb       = '0;
        bus.s_wr_data_last  = 1'b0;
        bus.m_wr_data_ready = '0;
        case (state)
            IDLE: begin
                if (arb_vld) state_nxt = ADDR;
            end
            ADDR: begin
                bus.s_wr_addr_valid      = 1'b1;
                bus.s_wr_addr_id         = ID_W'(gnt);
                bus.s_wr_addr            = bus.m_wr_addr[int'(gnt)*AW +: AW];
                bus.s_wr_addr_len        = bus.m_wr_addr_len[int'(gnt)*LEN_W +: LEN_W];
                bus.s_wr_addr_burst      = bus.m_wr_addr_burst[int'(gnt)*BURST_W +: BURST_W];
                bus.m_wr_addr_ready[gnt] = bus.s_wr_addr_ready;
                if (addr_hs) state_nxt = DATA;
            end
            DATA: begin
                bus.s_wr_data_valid      = bus.m_wr_data_valid[gnt];
                bus.s_wr_data            = bus.m_wr_data[int'(gnt)*DW +: DW];
                bus.s_wr_strb            = bus.m_wr_strb[int'(gnt)*SW +: SW];
                bus.s_wr_data_last       = data_last;
                bus.m_wr_data_ready[gnt] = bus.s_wr_data_ready;
                if (data_hs && data_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, beat counter and sticky burst-length error
    always_ff @(posedge B_CLK or negedge B_RSTN) begin
        if (!B_RSTN) begin
            gnt        <= '0;
            last_grant <= GW'(NUM_M - 1);
            beat_cnt   <= '0;
            burst_err  <= 1'b0;
        end else begin
            if ((state == IDLE) && arb_vld) gnt <= arb_idx;
            if (addr_hs) beat_cnt <= bus.m_wr_addr_len[int'(gnt)*LEN_W +: LEN_W];
            if (data_hs) begin
                if (data_last) begin
                    last_grant <= gnt;
                    beat_cnt   <= '0;
                    if (beat_cnt != '0) burst_err <= 1'b1;
                end else if (beat_cnt == '0) begin
                    burst_err <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt - LEN_W'(1);
                end
            end
        end
    end

    // Response demux by ID; unknown IDs are accepted and dropped
    always_comb begin
        bus.m_wr_back_resp  = {NUM_M{bus.s_wr_back_resp}};
        bus.m_wr_back_valid = '0;
        bus.s_wr_back_ready = 1'b1;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (bus.s_wr_back_id == ID_W'(i)) begin
                bus.m_wr_back_valid[i] = bus.s_wr_back_valid;
                bus.s_wr_back_ready    = bus.m_wr_back_ready[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_bus_wr_arbiter.sv
// Directed self-checking bench for axi_bus_wr_arbiter (NUM_M=4, AW=DW=32).
module tb_axi_bus_wr_arbiter;

    localparam int unsigned NUM_M = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic burst_err;
    int   n_cmp = 0;
    int   n_err = 0;

    axi_bus_wr_arbiter_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus ();

    axi_bus_wr_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) dut (
        .B_CLK     (clk),
        .B_RSTN    (rst_n),
        .bus       (bus.master),
        .burst_err (burst_err)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.m_wr_addr_valid = '0;
        bus.m_wr_addr       = '0;
        bus.m_wr_addr_len   = '0;
        bus.m_wr_addr_burst = '0;
        bus.m_wr_data_valid = '0;
        bus.m_wr_data       = '0;
        bus.m_wr_strb       = '0;
        bus.m_wr_data_last  = '0;
        bus.m_wr_back_ready = '0;
        bus.s_wr_addr_ready = 1'b0;
        bus.s_wr_data_ready = 1'b0;
        bus.s_wr_back_valid = 1'b0;
        bus.s_wr_back_id    = '0;
        bus.s_wr_back_resp  = '0;
    endtask

    task automatic set_addr(input int m, input logic [AW-1:0] a, input logic [7:0] len, input logic v);
        bus.m_wr_addr[m*AW +: AW]      = a;
        bus.m_wr_addr_len[m*8 +: 8]    = len;
        bus.m_wr_addr_burst[m*2 +: 2]  = 2'b01;
        bus.m_wr_addr_valid[m]         = v;
    endtask

    task automatic set_data(input int m, input logic [DW-1:0] d, input logic last, input logic v);
        bus.m_wr_data[m*DW +: DW] = d;
        bus.m_wr_strb[m*SW +: SW] = d[SW-1:0];
        bus.m_wr_data_last[m]     = last;
        bus.m_wr_data_valid[m]    = v;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        bus.m_wr_addr_valid = 4'hF;
        bus.s_wr_addr_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bus.s_wr_addr_valid !== 1'b0) begin n_err++; $display("FAIL reset_addr_valid: got %0h want 0", bus.s_wr_addr_valid); end
        n_cmp++; if (bus.s_wr_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid: got %0h want 0", bus.s_wr_data_valid); end
        n_cmp++; if (bus.m_wr_addr_ready !== 4'h0) begin n_err++; $display("FAIL reset_addr_ready: got %0h want 0", bus.m_wr_addr_ready); end
        n_cmp++; if (bus.m_wr_data_ready !== 4'h0) begin n_err++; $display("FAIL reset_data_ready: got %0h want 0", bus.m_wr_data_ready); end
        n_cmp++; if (burst_err !== 1'b0) begin n_err++; $display("FAIL reset_burst_err: got %0h want 0", burst_err); end
        n_cmp++; if (bus.s_wr_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr_bus: got %0h want 0", bus.s_wr_addr); end
        clear_inputs();
    endtask

    task automatic test_single_burst();
        do_reset();
        set_addr(0, 32'h0000_1000, 8'd3, 1'b1);
        bus.s_wr_addr_ready = 1'b1;
        bus.s_wr_data_ready = 1'b1;
        #1;
        n_cmp++; if (bus.s_wr_addr_valid !== 1'b0) begin n_err++; $display("FAIL t1_no_comb_path: got %0h want 0", bus.s_wr_addr_valid); end
        @(negedge clk); #1;
        n_cmp++; if (bus.s_wr_addr_valid !== 1'b1) begin n_err++; $display("FAIL t1_addr_valid: got %0h want 1", bus.s_wr_addr_valid); end
        n_cmp++; if (bus.s_wr_addr_id !== 2'd0) begin n_err++; $display("FAIL t1_addr_id: got %0h want 0", bus.s_wr_addr_id); end
        n_cmp++; if (bus.s_wr_addr !== 32'h0000_1000) begin n_err++; $display("FAIL t1_addr: got %0h want 1000", bus.s_wr_addr); end
        n_cmp++; if (bus.s_wr_addr_len !== 8'd3) begin n_err++; $display("FAIL t1_len: got %0h want 3", bus.s_wr_addr_len); end
        n_cmp++; if (bus.s_wr_addr_burst !== 2'b01) begin n_err++; $display("FAIL t1_burst: got %0h want 1", bus.s_wr_addr_burst); end
        n_cmp++; if (bus.m_wr_addr_ready !== 4'b0001) begin n_err++; $display("FAIL t1_addr_ready: got %0h want 1", bus.m_wr_addr_ready); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) set_addr(0, 32'h0000_1000, 8'd3, 1'b0);
            set_data(0, 32'hA000_0000 + 32'(b), (b == 3), 1'b1);
            #1;
            n_cmp++; if (bus.s_wr_data_valid !== 1'b1) begin n_err++; $display("FAIL t1_data_valid b%0d: got %0h want 1", b, bus.s_wr_data_valid); end
            n_cmp++; if (bus.s_wr_data !== 32'hA000_0000 + 32'(b)) begin n_err++; $display("FAIL t1_data b%0d: got %0h want %0h", b, bus.s_wr_data, 32'hA000_0000 + 32'(b)); end
            n_cmp++; if (bus.s_wr_data_last !== (b == 3)) begin n_err++; $display("FAIL t1_last b%0d: got %0h want %0h", b, bus.s_wr_data_last, (b == 3)); end
            n_cmp++; if (bus.m_wr_data_ready !== 4'b0001) begin n_err++; $display("FAIL t1_data_ready b%0d: got %0h want 1", b, bus.m_wr_data_ready); end
        end
        @(negedge clk);
        set_data(0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus.s_wr_data_valid !== 1'b0) begin n_err++; $display("FAIL t1_idle_valid: got %0h want 0", bus.s_wr_data_valid); end
        n_cmp++; if (bus.s_wr_data !== 32'h0) begin n_err++; $display("FAIL t1_idle_bus_mask: got %0h want 0", bus.s_wr_data); end
        n_cmp++; if (bus.s_wr_addr_valid !== 1'b0) begin n_err++; $display("FAIL t1_idle_addr_valid: got %0h want 0", bus.s_wr_addr_valid); end
        n_cmp++; if (burst_err !== 1'b0) begin n_err++; $display("FAIL t1_burst_err: got %0h want 0", burst_err); end
    endtask

    task automatic test_round_robin();
        logic [1:0] e;
        do_reset();
        bus.s_wr_addr_ready = 1'b1;
        bus.s_wr_data_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            set_addr(m, 32'h100 * 32'(m + 1), 8'd0, 1'b1);
            set_data(m, 32'hD0 + 32'(m), 1'b1, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            e = 2'(k % 4);
            @(negedge clk); #1;
            n_cmp++; if (bus.s_wr_addr_valid !== 1'b1 || bus.s_wr_addr_id !== e) begin n_err++; $display("FAIL t2_grant k%0d: got v=%0h id=%0h want v=1 id=%0h", k, bus.s_wr_addr_valid, bus.s_wr_addr_id, e); end
            n_cmp++; if (bus.m_wr_addr_ready !== 4'(1 << e)) begin n_err++; $display("FAIL t2_addr_ready k%0d: got %0h want %0h", k, bus.m_wr_addr_ready, 4'(1 << e)); end
            n_cmp++; if (bus.s_wr_data_valid !== 1'b0) begin n_err++; $display("FAIL t2_no_data_in_addr k%0d: got %0h want 0", k, bus.s_wr_data_valid); end
            @(negedge clk); #1;
            n_cmp++; if (bus.s_wr_data !== 32'hD0 + 32'(e)) begin n_err++; $display("FAIL t2_data_src k%0d: got %0h want %0h", k, bus.s_wr_data, 32'hD0 + 32'(e)); end
            n_cmp++; if (bus.m_wr_data_ready !== 4'(1 << e)) begin n_err++; $display("FAIL t2_data_ready k%0d: got %0h want %0h", k, bus.m_wr_data_ready, 4'(1 << e)); end
            @(negedge clk); #1;
            n_cmp++; if (bus.s_wr_addr_valid !== 1'b0 || bus.s_wr_data_valid !== 1'b0) begin n_err++; $display("FAIL t2_idle k%0d: got av=%0h dv=%0h want 0 0", k, bus.s_wr_addr_valid, bus.s_wr_data_valid); end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.s_wr_addr_ready = 1'b1;
        bus.s_wr_data_ready = 1'b1;
        set_addr(1, 32'h0000_7000, 8'd0, 1'b1);
        set_data(1, 32'h0000_7777, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.s_wr_addr_valid !== 1'b1 || bus.s_wr_addr_id !== 2'd1) begin n_err++; $display("FAIL b2b_addr k%0d: got v=%0h id=%0h want v=1 id=1", k, bus.s_wr_addr_valid, bus.s_wr_addr_id); end
            @(negedge clk); #1;
            n_cmp++; if (bus.s_wr_data_valid !== 1'b1 || bus.s_wr_data !== 32'h0000_7777) begin n_err++; $display("FAIL b2b_data k%0d: got v=%0h d=%0h want v=1 d=7777", k, bus.s_wr_data_valid, bus.s_wr_data); end
            @(negedge clk); #1;
            n_cmp++; if (bus.s_wr_addr_valid !== 1'b0 || bus.s_wr_data_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle k%0d: got av=%0h dv=%0h want 0 0", k, bus.s_wr_addr_valid, bus.s_wr_data_valid); end
        end
        clear_inputs();
    endtask

    task automatic test_data_stall();
        int   b;
        int   seen;
        logic rdy;
        b    = 0;
        seen = 0;
        do_reset();
        set_addr(0, 32'h0000_2000, 8'd7, 1'b1);
        bus.s_wr_addr_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bus.s_wr_addr_valid !== 1'b1 || bus.s_wr_addr_len !== 8'd7) begin n_err++; $display("FAIL t3_addr: got v=%0h len=%0h want v=1 len=7", bus.s_wr_addr_valid, bus.s_wr_addr_len); end
        @(negedge clk);
        set_addr(0, 32'h0000_2000, 8'd7, 1'b0);
        for (int c = 0; c < 40; c++) begin
            if (b == 8) break;
            rdy = (c % 2 == 0);
            bus.s_wr_data_ready = rdy;
            set_data(0, 32'hB000_0000 + 32'(b), (b == 7), 1'b1);
            #1;
            n_cmp++; if (bus.s_wr_data !== 32'hB000_0000 + 32'(b) || bus.s_wr_data_valid !== 1'b1) begin n_err++; $display("FAIL t3_hold c%0d: got v=%0h d=%0h want v=1 d=%0h", c, bus.s_wr_data_valid, bus.s_wr_data, 32'hB000_0000 + 32'(b)); end
            n_cmp++; if (bus.m_wr_data_ready !== {3'b000, rdy}) begin n_err++; $display("FAIL t3_ready c%0d: got %0h want %0h", c, bus.m_wr_data_ready, {3'b000, rdy}); end
            if (bus.s_wr_data_valid && rdy) begin
                n_cmp++; if (bus.s_wr_data !== 32'hB000_0000 + 32'(seen) || bus.s_wr_data_last !== (seen == 7)) begin n_err++; $display("FAIL t3_beat%0d: got d=%0h l=%0h want d=%0h l=%0h", seen, bus.s_wr_data, bus.s_wr_data_last, 32'hB000_0000 + 32'(seen), (seen == 7)); end
                seen++;
            end
            if (bus.m_wr_data_ready[0]) b++;
            @(negedge clk);
        end
        set_data(0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (seen !== 8) begin n_err++; $display("FAIL t3_beat_count: got %0d want 8", seen); end
        n_cmp++; if (bus.s_wr_data_valid !== 1'b0 || burst_err !== 1'b0) begin n_err++; $display("FAIL t3_end: got dv=%0h err=%0h want 0 0", bus.s_wr_data_valid, burst_err); end
        clear_inputs();
    endtask

    task automatic test_back_channel();
        @(negedge clk);
        bus.s_wr_back_valid = 1'b1;
        bus.s_wr_back_id    = 2'd2;
        bus.s_wr_back_resp  = 2'b10;
        bus.m_wr_back_ready = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (bus.m_wr_back_valid !== 4'b0100) begin n_err++; $display("FAIL t4_valid c%0d: got %0h want 4", c, bus.m_wr_back_valid); end
            n_cmp++; if (bus.s_wr_back_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_low c%0d: got %0h want 0", c, bus.s_wr_back_ready); end
            n_cmp++; if (bus.m_wr_back_resp !== 8'b1010_1010) begin n_err++; $display("FAIL t4_resp c%0d: got %0h want aa", c, bus.m_wr_back_resp); end
            @(negedge clk);
        end
        bus.m_wr_back_ready = 4'b1111;
        #1;
        n_cmp++; if (bus.s_wr_back_ready !== 1'b1 || bus.m_wr_back_valid !== 4'b0100) begin n_err++; $display("FAIL t4_accept: got r=%0h v=%0h want r=1 v=4", bus.s_wr_back_ready, bus.m_wr_back_valid); end
        @(negedge clk);
        bus.s_wr_back_id    = 2'd0;
        bus.s_wr_back_resp  = 2'b01;
        bus.m_wr_back_ready = 4'b1110;
        #1;
        n_cmp++; if (bus.m_wr_back_valid !== 4'b0001 || bus.s_wr_back_ready !== 1'b0) begin n_err++; $display("FAIL t4_id0: got v=%0h r=%0h want v=1 r=0", bus.m_wr_back_valid, bus.s_wr_back_ready); end
        @(negedge clk);
        bus.s_wr_back_valid = 1'b0;
        #1;
        n_cmp++; if (bus.m_wr_back_valid !== 4'b0000) begin n_err++; $display("FAIL t4_none: got %0h want 0", bus.m_wr_back_valid); end
        clear_inputs();
    endtask

    task automatic test_burst_err();
        do_reset();
        bus.s_wr_addr_ready = 1'b1;
        bus.s_wr_data_ready = 1'b1;
        set_addr(0, 32'h0000_3000, 8'd3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        set_addr(0, 32'h0000_3000, 8'd3, 1'b0);
        set_data(0, 32'hE0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (burst_err !== 1'b0) begin n_err++; $display("FAIL t5_err_before: got %0h want 0", burst_err); end
        @(negedge clk);
        set_data(0, 32'hE1, 1'b1, 1'b1);
        #1;
        n_cmp++; if (burst_err !== 1'b0 || bus.s_wr_data_last !== 1'b1) begin n_err++; $display("FAIL t5_early_last: got err=%0h last=%0h want 0 1", burst_err, bus.s_wr_data_last); end
        @(negedge clk);
        set_data(0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (burst_err !== 1'b1) begin n_err++; $display("FAIL t5_err_set: got %0h want 1", burst_err); end
        n_cmp++; if (bus.s_wr_data_valid !== 1'b0 || bus.s_wr_addr_valid !== 1'b0) begin n_err++; $display("FAIL t5_idle: got dv=%0h av=%0h want 0 0", bus.s_wr_data_valid, bus.s_wr_addr_valid); end
        set_addr(1, 32'h0000_3100, 8'd0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (burst_err !== 1'b1) begin n_err++; $display("FAIL t5_sticky: got %0h want 1", burst_err); end
        clear_inputs();
    endtask

    task automatic test_missing_last();
        do_reset();
        bus.s_wr_addr_ready = 1'b1;
        bus.s_wr_data_ready = 1'b1;
        set_addr(2, 32'h0000_4000, 8'd0, 1'b1);
        @(negedge clk); #1;
        n_cmp++; if (bus.s_wr_addr_id !== 2'd2 || bus.s_wr_addr_valid !== 1'b1) begin n_err++; $display("FAIL ml_grant: got v=%0h id=%0h want v=1 id=2", bus.s_wr_addr_valid, bus.s_wr_addr_id); end
        @(negedge clk);
        set_addr(2, 32'h0000_4000, 8'd0, 1'b0);
        set_data(2, 32'hF0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (burst_err !== 1'b0 || bus.m_wr_data_ready !== 4'b0100) begin n_err++; $display("FAIL ml_beat0: got err=%0h rdy=%0h want 0 4", burst_err, bus.m_wr_data_ready); end
        @(negedge clk);
        set_data(2, 32'hF1, 1'b0, 1'b1);
        #1;
        n_cmp++; if (burst_err !== 1'b1) begin n_err++; $display("FAIL ml_err: got %0h want 1", burst_err); end
        n_cmp++; if (bus.s_wr_data_valid !== 1'b1 || bus.s_wr_data !== 32'hF1 || bus.m_wr_data_ready !== 4'b0100) begin n_err++; $display("FAIL ml_held: got v=%0h d=%0h rdy=%0h want 1 f1 4", bus.s_wr_data_valid, bus.s_wr_data, bus.m_wr_data_ready); end
        @(negedge clk);
        set_data(2, 32'hF2, 1'b1, 1'b1);
        #1;
        n_cmp++; if (bus.s_wr_data_valid !== 1'b1 || bus.s_wr_data !== 32'hF2) begin n_err++; $display("FAIL ml_last_beat: got v=%0h d=%0h want 1 f2", bus.s_wr_data_valid, bus.s_wr_data); end
        @(negedge clk);
        set_data(2, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus.s_wr_data_valid !== 1'b0 || bus.s_wr_addr_valid !== 1'b0) begin n_err++; $display("FAIL ml_idle: got dv=%0h av=%0h want 0 0", bus.s_wr_data_valid, bus.s_wr_addr_valid); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.s_wr_addr_ready = 1'b1;
        bus.s_wr_data_ready = 1'b1;
        set_addr(0, 32'h0000_5000, 8'd0, 1'b1);
        set_data(0, 32'hC000, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        set_addr(0, 32'h0000_5000, 8'd0, 1'b0);
        @(negedge clk);
        set_data(0, 32'h0, 1'b0, 1'b0);
        set_addr(1, 32'h0000_5100, 8'd3, 1'b1);
        @(negedge clk); #1;
        n_cmp++; if (bus.s_wr_addr_id !== 2'd1 || bus.s_wr_addr_valid !== 1'b1) begin n_err++; $display("FAIL t6_grant_m1: got v=%0h id=%0h want v=1 id=1", bus.s_wr_addr_valid, bus.s_wr_addr_id); end
        @(negedge clk);
        set_addr(1, 32'h0000_5100, 8'd3, 1'b0);
        set_data(1, 32'hC100, 1'b0, 1'b1);
        #1;
        n_cmp++; if (bus.s_wr_data_valid !== 1'b1 || bus.s_wr_data !== 32'hC100) begin n_err++; $display("FAIL t6_beat0: got v=%0h d=%0h want 1 c100", bus.s_wr_data_valid, bus.s_wr_data); end
        @(negedge clk);
        set_data(1, 32'hC101, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.s_wr_data_valid !== 1'b0 || bus.m_wr_data_ready !== 4'h0) begin n_err++; $display("FAIL t6_rst_data: got v=%0h rdy=%0h want 0 0", bus.s_wr_data_valid, bus.m_wr_data_ready); end
        n_cmp++; if (bus.s_wr_data !== 32'h0 || bus.s_wr_addr_valid !== 1'b0 || burst_err !== 1'b0) begin n_err++; $display("FAIL t6_rst_bus: got d=%0h av=%0h err=%0h want 0 0 0", bus.s_wr_data, bus.s_wr_addr_valid, burst_err); end
        set_data(1, 32'h0, 1'b0, 1'b0);
        set_addr(0, 32'h0000_5200, 8'd0, 1'b1);
        set_addr(1, 32'h0000_5300, 8'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bus.s_wr_addr_valid !== 1'b1 || bus.s_wr_addr_id !== 2'd0 || bus.s_wr_addr !== 32'h0000_5200) begin n_err++; $display("FAIL t6_regrant_m0: got v=%0h id=%0h a=%0h want 1 0 5200", bus.s_wr_addr_valid, bus.s_wr_addr_id, bus.s_wr_addr); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_back_to_back();
        test_data_stall();
        test_back_channel();
        test_burst_err();
        test_missing_last();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
